// File: rtl/riscv_pkg.sv
// Shared RISC-V control definitions: opcode constants and multi-cycle state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_TRAP    = 3'd7
  } state_e;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath-side bundle of the multi-cycle sequencer: decode inputs, memory handshake, strobes.
interface multicycle_control_if;

  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       mem_read;
  logic       mem_write;
  logic       mem_addr_sel;
  logic       alu_src;
  logic       mem_to_reg;
  logic       reg_write;
  logic       branch;
  logic       jump;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output ir_write, pc_write, pc_src, mem_read, mem_write, mem_addr_sel,
           alu_src, mem_to_reg, reg_write, branch, jump
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  ir_write, pc_write, pc_src, mem_read, mem_write, mem_addr_sel,
           alu_src, mem_to_reg, reg_write, branch, jump
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access stalls; flags the last allowed stall cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int              W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count_q <= '0;
    else if (clear)                count_q <= '0;
    else if (waiting && !expired)  count_q <= count_q + 1'b1;
  end

  assign expired = waiting && (count_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V sequencer: FETCH/DECODE/EXECUTE/MEM/WB with shared memory port and traps.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  multicycle_control_if.master dp,
  output logic [2:0]           state,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [CNT_W-1:0]     instret
);

  state_e state_q, state_next;
  logic   waiting, expired, timer_clear, timeout_trap, illegal_trap;
  logic   ir_write, pc_write, pc_src, mem_read, mem_write, mem_addr_sel;
  logic   alu_src, mem_to_reg, reg_write, branch, jump;

  wire op_load  = (dp.opcode == OP_LOAD);
  wire op_store = (dp.opcode == OP_STORE);
  wire op_jmp   = (dp.opcode == OP_JAL) || (dp.opcode == OP_JALR);

  assign waiting     = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !dp.mem_ready;
  assign timer_clear = ((state_next == ST_FETCH) || (state_next == ST_MEM)) &&
                       (state_next != state_q);

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    timeout_trap = 1'b0;
    illegal_trap = 1'b0;

    case (state_q)
      ST_IDLE: if (run) state_next = ST_FETCH;

      ST_FETCH: begin
        mem_read = 1'b1;
        if (dp.mem_ready) begin
          ir_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (expired) begin
          timeout_trap = 1'b1;
          state_next   = ST_TRAP;
        end
      end

      ST_DECODE: begin
        illegal_trap = !is_legal(dp.opcode);
        state_next   = illegal_trap ? ST_TRAP : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        alu_src = (dp.opcode == OP_I) || op_load || op_store || (dp.opcode == OP_JALR);
        jump    = op_jmp;
        if (dp.opcode == OP_BRANCH) begin
          branch     = 1'b1;
          pc_write   = 1'b1;
          pc_src     = dp.branch_taken;
          state_next = run ? ST_FETCH : ST_IDLE;
        end else if (op_load || op_store) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_MEM: begin
        mem_addr_sel = 1'b1;
        alu_src      = 1'b1;
        mem_read     = op_load;
        mem_write    = op_store;
        if (dp.mem_ready) begin
          if (op_store) begin
            pc_write   = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
          end else begin
            state_next = ST_WB;
          end
        end else if (expired) begin
          timeout_trap = 1'b1;
          state_next   = ST_TRAP;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = op_load;
        jump       = op_jmp;
        pc_src     = op_jmp;
        alu_src    = (dp.opcode == OP_I) || (dp.opcode == OP_JALR);
        state_next = run ? ST_FETCH : ST_IDLE;
      end

      ST_TRAP: state_next = ST_TRAP;

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret       <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      if (pc_write)     instret       <= instret + CNT_W'(1);
      if (illegal_trap) illegal_instr <= 1'b1;
      if (timeout_trap) bus_error     <= 1'b1;
    end
  end

  assign state           = state_q;
  assign dp.ir_write     = ir_write;
  assign dp.pc_write     = pc_write;
  assign dp.pc_src       = pc_src;
  assign dp.mem_read     = mem_read;
  assign dp.mem_write    = mem_write;
  assign dp.mem_addr_sel = mem_addr_sel;
  assign dp.alu_src      = alu_src;
  assign dp.mem_to_reg   = mem_to_reg;
  assign dp.reg_write    = reg_write;
  assign dp.branch       = branch;
  assign dp.jump         = jump;

endmodule
